// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage, word reads split into halfword insns.
// Optional CORE_FETCH_BYPASS_EN: response halfword may skip the prefetch FIFO.
module core_fetch #(
  parameter int          PREFETCH_DEPTH = 4,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] target,
  output logic [15:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  output logic [29:0] mem_addr,
  output logic        mem_start,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int AW = $clog2(PREFETCH_DEPTH);
  localparam logic [AW:0] SPACE_LIM = (AW+1)'(PREFETCH_DEPTH - 2);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          pending_q, pending_d;
  logic          discard_q, discard_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   insn_q, insn_d;
  logic [31:0]   ipc_q, ipc_d;
  logic          ival_q, ival_d;

  logic [15:0]   fhw_q [PREFETCH_DEPTH];
  logic [31:0]   fpc_q [PREFETCH_DEPTH];

  logic          resp, take, lo, load, empty, pop, byp;
  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [15:0]   e0_hw, e1_hw, w0_hw;
  logic [31:0]   e0_pc, e1_pc, w0_pc;
  logic          unused_tgt;

  assign unused_tgt = target[0];

  assign resp  = mem_ready && pending_q;
  assign take  = resp && !discard_q && !flush;
  assign lo    = !fetch_pc_q[1];
  assign e0_hw = lo ? mem_data[15:0] : mem_data[31:16];
  assign e0_pc = {fetch_pc_q[31:2], lo ? 2'b00 : 2'b10};
  assign e1_hw = mem_data[31:16];
  assign e1_pc = {fetch_pc_q[31:2], 2'b10};
  assign load  = !ival_q || !stall;
  assign empty = (cnt_q == '0);
  assign pop   = load && !empty && !flush;
`ifdef CORE_FETCH_BYPASS_EN
  assign byp   = load && empty && take;
`else
  assign byp   = 1'b0;
`endif

  assign mem_addr   = fetch_pc_q[31:2];
  assign mem_start  = !rst && !pending_q && !flush
                      && (cnt_q <= SPACE_LIM);
  assign insn       = insn_q;
  assign insn_pc    = ipc_q;
  assign insn_valid = ival_q;

  // next-state: request, response push, output load, flush override
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    insn_d     = insn_q;
    ipc_d      = ipc_q;
    ival_d     = ival_q;
    we0        = 1'b0;
    we1        = 1'b0;
    wa0        = rd_q + cnt_q[AW-1:0];
    wa1        = wa0 + 1'b1;
    w0_hw      = e0_hw;
    w0_pc      = e0_pc;

    if (mem_start) pending_d = 1'b1;

    if (resp) begin
      pending_d = 1'b0;
      discard_d = 1'b0;
      if (!discard_q)
        fetch_pc_d = {fetch_pc_q[31:2] + 30'd1, 2'b00};
    end

    if (take) begin
      if (byp) begin
        we0   = lo;
        w0_hw = e1_hw;
        w0_pc = e1_pc;
      end else begin
        we0 = 1'b1;
        we1 = lo;
      end
    end

    if (load) begin
      if (pop) begin
        insn_d = fhw_q[rd_q];
        ipc_d  = fpc_q[rd_q];
        ival_d = 1'b1;
      end else if (byp) begin
        insn_d = e0_hw;
        ipc_d  = e0_pc;
        ival_d = 1'b1;
      end else begin
        ival_d = 1'b0;
      end
    end

    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q - (AW+1)'(pop)
            + (AW+1)'(we0) + (AW+1)'(we1);

    if (flush) begin
      cnt_d      = '0;
      ival_d     = 1'b0;
      fetch_pc_d = {target[31:1], 1'b0};
      if (pending_q && !mem_ready) discard_d = 1'b1;
    end
  end

  // control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      insn_q     <= '0;
      ipc_q      <= RESET_PC;
      ival_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      insn_q     <= insn_d;
      ipc_q      <= ipc_d;
      ival_q     <= ival_d;
    end
  end

  // FIFO storage; contents only meaningful below cnt_q
  always_ff @(posedge clk) begin
    if (we0) begin
      fhw_q[wa0] <= w0_hw;
      fpc_q[wa0] <= w0_pc;
    end
    if (we1) begin
      fhw_q[wa1] <= e1_hw;
      fpc_q[wa1] <= e1_pc;
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: randomized bench for core_fetch with a PC-stream model.
// Directed scenarios pin the model with literal expectations.
module tb_core_fetch;

`ifdef CORE_FETCH_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = '0;
  logic [15:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic [29:0] mem_addr;
  logic        mem_start;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = '0;

  always #5 clk = ~clk;

  core_fetch #(
    .PREFETCH_DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .target(target),
    .insn(insn),
    .insn_pc(insn_pc),
    .insn_valid(insn_valid),
    .mem_addr(mem_addr),
    .mem_start(mem_start),
    .mem_ready(mem_ready),
    .mem_data(mem_data)
  );

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  logic [31:0] mem [logic [29:0]];

  logic [31:0] exp_pc, exp_req, cur_tg;
  logic [29:0] req_addr, s_addr;
  logic [29:0] rlog [$];
  int          epoch = 0, req_ep = 0, cur_rep = 0;
  int          lat = 0, lat_lo = 1, lat_hi = 1, starve = 0;
  bit          busy, cur_rdy, cur_st, cur_fl, flushed_prev;
  bit          s_start, s_valid;

  function automatic logic [31:0] rdmem(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[13:0], 2'b11, a[13:0], 2'b01} ^ 32'h6B2D_91C4;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = rdmem(pc[31:2]);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic compare();
    s_start = (mem_start === 1'b1);
    s_addr  = mem_addr;
    s_valid = (insn_valid === 1'b1);
    if (flushed_prev)
      chk("flush_kills_valid", 32'(insn_valid), 32'd0);
    if (s_valid) begin
      chk("insn_pc", insn_pc, exp_pc);
      chk("insn", 32'(insn), 32'(hw_at(exp_pc)));
    end
    if (s_start) begin
      chk("req_addr", 32'(mem_addr), 32'(exp_req[31:2]));
      chk("req_legal",
          32'(!busy && !flush && !(cur_rdy && cur_rep >= 0)), 32'd1);
    end
    if (!stall) begin
      if (s_valid) starve = 0;
      else starve++;
    end
    if (starve > 40) begin
      total++;
      bad++;
      $display("FAIL starve: idle %0d cycles, expected an insn", starve);
      starve = 0;
    end
  endtask

  task automatic cyc(input bit st, input bit fl, input logic [31:0] tg);
    @(posedge clk);
    #1;
    cyc_n++;
    if (cur_rdy && cur_rep == epoch && !cur_fl)
      exp_req = {exp_req[31:2] + 30'd1, 2'b00};
    if (s_start) begin
      busy     = 1'b1;
      lat      = $urandom_range(lat_lo, lat_hi);
      req_addr = s_addr;
      req_ep   = epoch;
      rlog.push_back(s_addr);
    end
    if (cur_fl) begin
      exp_pc  = {cur_tg[31:1], 1'b0};
      exp_req = exp_pc;
      epoch++;
    end else if (s_valid && !cur_st) begin
      exp_pc = exp_pc + 32'd2;
    end
    flushed_prev = cur_fl;
    mem_ready = 1'b0;
    cur_rdy   = 1'b0;
    if (busy) begin
      lat--;
      if (lat == 0) begin
        busy      = 1'b0;
        mem_ready = 1'b1;
        mem_data  = rdmem(req_addr);
        cur_rdy   = 1'b1;
        cur_rep   = req_ep;
      end
    end
    stall  = st;
    flush  = fl;
    target = tg;
    cur_st = st;
    cur_fl = fl;
    cur_tg = tg;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input bit stray);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    busy = 1'b0;
    cur_rdy = 1'b0;
    cur_st = 1'b0;
    cur_fl = 1'b0;
    flushed_prev = 1'b0;
    s_start = 1'b0;
    s_valid = 1'b0;
    exp_pc = 32'h0;
    exp_req = 32'h0;
    starve = 0;
    epoch++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_insn", 32'(insn), 32'd0);
    chk("rst_pc", insn_pc, 32'h0);
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_start", 32'(mem_start), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_n++;
    if (stray) begin
      mem_ready = 1'b1;
      mem_data  = 32'hDEAD_BEEF;
      cur_rdy   = 1'b1;
      cur_rep   = -1;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (insn_valid !== 1'b1 && k < 20) begin
      cyc(1'b0, 1'b0, 32'h0);
      k++;
    end
    chk(nm, 32'(insn_valid), 32'd1);
  endtask

  task automatic wait_busy();
    int k = 0;
    while (!(busy && !mem_ready) && k < 30) begin
      cyc(1'b0, 1'b0, 32'h0);
      k++;
    end
  endtask

  initial begin
    int r, v, sr, ns;
    bit ok, st, fl;
    logic [31:0] tg;
    mem[30'h0]  = 32'hBBBB_AAAA;
    mem[30'h41] = 32'h2222_1111;
    lat_lo = 1;
    lat_hi = 1;

    do_reset(1'b0);
    chk("t1_start", 32'(mem_start), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd0);
    r = -1;
    v = -1;
    for (int k = 0; k < 12 && v < 0; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (mem_ready === 1'b1 && r < 0) r = k;
      if (insn_valid === 1'b1 && v < 0) v = k;
    end
    chk("rdy_to_valid", 32'(v - r - 1), 32'(EXP_LAT));
    chk("t1_insn0", 32'(insn), 32'h0000_AAAA);
    chk("t1_pc0", insn_pc, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t1_valid1", 32'(insn_valid), 32'd1);
    chk("t1_insn1", 32'(insn), 32'h0000_BBBB);
    chk("t1_pc1", insn_pc, 32'h2);
    chk("t1_req1", 32'(rlog.size() >= 2 ? rlog[1] : 30'h3FFF_FFFF), 32'h1);

    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 32'h0);
    chk("stall_pc", insn_pc, 32'h4);
    chk("stall_valid", 32'(insn_valid), 32'd1);
    chk("stall_no_req", 32'(mem_start), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (insn_valid !== 1'b1) ok = 1'b0;
    end
    chk("sustain", 32'(ok), 32'd1);

    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0106);
    chk("flush_no_start", 32'(mem_start), 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("flush_start", 32'(mem_start), 32'd1);
    chk("flush_addr", 32'(mem_addr), 32'h41);
    wait_valid("flush_wait0");
    chk("flush_insn", 32'(insn), 32'h0000_2222);
    chk("flush_pc", insn_pc, 32'h106);
    cyc(1'b0, 1'b0, 32'h0);
    wait_valid("flush_wait1");
    chk("flush_next_pc", insn_pc, 32'h108);

    lat_lo = 3;
    lat_hi = 3;
    wait_busy();
    cyc(1'b0, 1'b1, 32'h0000_0200);
    sr = -1;
    ns = -1;
    for (int k = 0; k < 12 && ns < 0; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (mem_ready === 1'b1 && sr < 0) sr = cyc_n;
      if (mem_start === 1'b1 && ns < 0) begin
        ns = cyc_n;
        chk("redir_addr", 32'(mem_addr), 32'h80);
      end
    end
    chk("redir_after_discard", 32'(ns - sr), 32'd1);
    wait_valid("redir_wait");
    chk("redir_pc", insn_pc, 32'h200);

    wait_busy();
    do_reset(1'b1);
    wait_valid("rst_wait");
    chk("rst_insn0", 32'(insn), 32'h0000_AAAA);
    chk("rst_pc0", insn_pc, 32'h0);

    lat_lo = 1;
    lat_hi = 4;
    for (int k = 0; k < 4000; k++) begin
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0)
        tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else
        tg = $urandom & 32'h0001_FFFF;
      cyc(st, fl, tg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
# core_fetch

Instruction fetch stage of the 16-bit-instruction core. Issues word-sized reads to instruction memory, splits each 32-bit word into two halfword instructions, buffers them in a small prefetch FIFO and presents one registered instruction per cycle, with its PC, to `core_decode`. Handles branch redirects (flush) and downstream back-pressure (stall).

## Interface
- `PREFETCH_DEPTH`, 4: prefetch FIFO capacity in halfwords; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: byte address of the first instruction; bit 0 must be 0.

- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset; one clock, reset async active-high
- `stall`  in  1  decode cannot accept; hold `insn`/`insn_pc`/`insn_valid`
- `flush`  in  1  redirect fetch to `target`
- `target`  in  32  byte address of redirect; bit 0 ignored (treated as 0)
- `insn`  out  16  instruction to decode
- `insn_pc`  out  32  byte address of `insn`
- `insn_valid`  out  1  `insn` holds a real instruction
- `mem_addr`  out  30  word address of read request
- `mem_start`  out  1  one-cycle request strobe
- `mem_ready`  in  1  one-cycle response strobe, `mem_data` valid
- `mem_data`  in  32  read data; bits [15:0] = lower halfword address (little-endian)

## Operation
- State: `fetch_pc` (byte address of next halfword to request), `pending` (request outstanding), `discard` (drop next response), FIFO of {hword, pc} entries with count, output register.
- Request: assert `mem_start` for one cycle with `mem_addr = fetch_pc[31:2]` when `!pending && !flush` and FIFO free space ≥2 (count ≤ PREFETCH_DEPTH−2, accounting for pops in the same cycle not required). `mem_addr` held until response. Set `pending`.
- Response (`mem_ready && pending`): clear `pending`. If `discard`, drop data and clear `discard`. Else push hwords: if `fetch_pc[1]==0` push [15:0] at `fetch_pc` then [31:16] at `fetch_pc+2`; if `fetch_pc[1]==1` push only [31:16]. `fetch_pc` ← `{fetch_pc[31:2]+1, 2'b00}` (wraps modulo 2^32).
- `mem_ready` without `pending`: ignored.
- Output: when `!insn_valid || !stall`, load head of FIFO into `insn`/`insn_pc`, set `insn_valid=1` and pop; if FIFO empty, `insn_valid`←0 (`insn`/`insn_pc` keep last value).
- Flush (priority over stall and response): FIFO count←0, `insn_valid`←0, `fetch_pc`←`{target[31:1],1'b0}`; if `pending` and no `mem_ready` this cycle, set `discard`; if `mem_ready` this cycle, its data is dropped. No `mem_start` in the flush cycle.
- FIFO full: no request issued; pushes never overflow because of free-space check.

## Timing
- Reset values: `insn`=0, `insn_pc`=RESET_PC, `insn_valid`=0, `mem_start`=0, `mem_addr`=RESET_PC[31:2], `fetch_pc`=RESET_PC, `pending`=0, `discard`=0, FIFO empty.
- First `mem_start` in the first cycle after `rst` deasserts.
- Memory: `mem_ready` earliest one cycle after `mem_start`; one outstanding request.
- Latency without bypass: response sampled at edge N → FIFO at N, `insn_valid` at N+1.
- Reset mid-request: all state cleared; a later stray `mem_ready` is ignored (`pending`=0).
- Flush→`mem_start` at target: next cycle if no request outstanding, else the cycle after the discarded response.
- Throughput: 2 instructions per memory round-trip; sustained 1/cycle needs memory latency ≤ 1 cycle with PREFETCH_DEPTH ≥4.

## Configuration
- `CORE_FETCH_BYPASS_EN` defined: when the output register loads and FIFO is empty on a response cycle, the first pushed hword goes directly into `insn` at edge N (`insn_valid` at N); the remaining hword (if any) enters the FIFO.
- Undefined: all hwords pass through the FIFO; latency per Timing.

## Test plan
- Reset release, memory returns 32'hBBBB_AAAA for word 0 after 1 cycle, no stall → `insn`=AAAA pc 0, then BBBB pc 2, then next `mem_addr`=1.
- Flush to `target`=32'h0000_0106 with idle bus → `mem_addr`=30'h41, response 32'h2222_1111 → only 2222 delivered at pc 0x106, next pc 0x108.
- Flush while request outstanding (memory latency 3) → first response dropped, new `mem_addr` issued after it, no stale insn ever valid.
- `stall` held 10 cycles with continuous responses → `insn`/`insn_pc` unchanged, FIFO fills to PREFETCH_DEPTH, `mem_start` stops; release → instructions in order, none lost or duplicated.
- Assert `rst` with `pending`=1, then `mem_ready` pulse after release → ignored; fetch restarts at RESET_PC.
- Bypass build vs non-bypass: measure `mem_ready`→`insn_valid` = 0 vs 1 cycle after the sampling edge.
